// File: rtl/debounce_multi.sv
// debounce_multi: per-channel synchronise + tick-sampled debounce with rise/fall/hold pulses.
// All channels share one prescaler; every output is registered.
module debounce_multi #(
    parameter int CDIV        = 50_000,
    parameter int THRES       = 5,
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_TICKS  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] si,
    output logic [WIDTH-1:0] so,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] hold,
    output logic             tick
);
    localparam int CW = $clog2(THRES + 1);

    logic [31:0]                        pre_q, pre_d;
    logic                               tick_q, tick_d;
    logic [SYNC_STAGES-1:0][WIDTH-1:0]  sync_q, sync_d;
    logic [WIDTH-1:0][CW-1:0]           cnt_q, cnt_d;
    logic [WIDTH-1:0][15:0]             hc_q, hc_d;
    logic [WIDTH-1:0]                   so_q, so_d, rise_q, rise_d, fall_q, fall_d, hold_q, hold_d;
    logic [WIDTH-1:0]                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        pre_d  = (pre_q == 32'(CDIV - 1)) ? 32'd0 : pre_q + 32'd1;
        tick_d = pre_q == 32'(CDIV - 1);
        sync_d = sync_q;
        sync_d[0] = si;
        for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
    end

    always_comb begin
        cnt_d  = cnt_q;
        hc_d   = hc_q;
        so_d   = so_q;
        rise_d = '0;
        fall_d = '0;
        hold_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (tick_q) begin
                if (s[i] == so_q[i]) cnt_d[i] = '0;
                else if (32'(cnt_q[i]) + 32'd1 < THRES) cnt_d[i] = cnt_q[i] + CW'(1);
                else begin
                    so_d[i]   = s[i];
                    cnt_d[i]  = '0;
                    rise_d[i] = s[i];
                    fall_d[i] = !s[i];
                end
            end
            // hold count saturates at HOLD_TICKS so it fires once per press
            if (!so_q[i]) hc_d[i] = '0;
            else if (tick_q && hc_q[i] < 16'(HOLD_TICKS)) begin
                hc_d[i]   = hc_q[i] + 16'd1;
                hold_d[i] = (hc_d[i] == 16'(HOLD_TICKS)) && !fall_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
            sync_q <= '0;
            cnt_q  <= '0;
            hc_q   <= '0;
            so_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
            hold_q <= '0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            hc_q   <= hc_d;
            so_q   <= so_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            hold_q <= hold_d;
        end
    end

    assign so   = so_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign hold = hold_q;
    assign tick = tick_q;
endmodule

// File: doc/debounce_multi.md
# debounce_multi

Multi-channel, parameterised button/switch debouncer with event outputs. It synchronises each asynchronous input and samples all channels on a shared prescaled tick. A channel's debounced level changes only after THRES consecutive differing samples. Single-cycle rise, fall and long-press (hold) pulses are emitted per channel. The block sits between raw board inputs (buttons, DIP switches) and control logic, replacing the single-threshold debouncer and removing the need for downstream edge detectors.

## Interface
- CDIV, 50_000: clk cycles per sample tick; must be ≥1 (1 means a tick every cycle).
- THRES, 5: consecutive differing samples required to accept a new level; must be ≥1.
- WIDTH, 1: number of independent channels.
- SYNC_STAGES, 2: synchroniser flops per channel; must be ≥1.
- HOLD_TICKS, 0: ticks of sustained high before a hold pulse is emitted; 0 disables hold; must be ≤65535.

Ports:
- clk  input  1  sole clock.
- rst  input  1  synchronous, active-high reset.
- si  input  WIDTH  raw asynchronous inputs, active high.
- so  output  WIDTH  debounced levels, registered.
- rise  output  WIDTH  one-cycle pulse when so[i] goes 0→1.
- fall  output  WIDTH  one-cycle pulse when so[i] goes 1→0.
- hold  output  WIDTH  one-cycle pulse after so[i] has been high for HOLD_TICKS ticks.
- tick  output  1  one-cycle sample strobe, exported for neighbouring blocks.

## Operation
- Reset (rst high at a clk edge): prescaler, synchronisers, per-channel counters, hold counters and all outputs are cleared to 0. The effect is identical when reset is asserted mid-count.
- Synchroniser: a SYNC_STAGES-deep flop chain per bit. The last stage, s[i], is the only value the block uses.
- Prescaler: a 32-bit counter runs 0..CDIV-1 and wraps to 0. tick is registered high for exactly the one cycle in which the counter equals CDIV-1.
- Per-channel stability counter cnt[i] (width clog2(THRES+1)) changes only on a tick:
  - s[i]==so[i]: cnt[i] ← 0. A glitch shorter than THRES samples never reaches so.
  - s[i]!=so[i] and cnt[i]+1<THRES: cnt[i] ← cnt[i]+1.
  - s[i]!=so[i] and cnt[i]+1==THRES: so[i] ← s[i], cnt[i] ← 0, and rise[i] or fall[i] is pulsed in the same edge according to the new level.
- Hold counter hc[i] (16 bits):
  - Cleared whenever so[i]==0.
  - On a tick with so[i]==1 and hc[i]<HOLD_TICKS: hc[i] ← hc[i]+1. When the new value equals HOLD_TICKS, hold[i] pulses.
  - Saturates, so hold fires once per press.
  - With HOLD_TICKS=0, hold is constant 0.
- Channels are fully independent. Any combination may change on the same tick.
- rise[i], fall[i] and hold[i] are mutually exclusive within a cycle for a given i. The hold count starts on the first tick after the rise tick.

## Timing
- Latency with CDIV=1: so[i] changes SYNC_STAGES+THRES clk cycles after si[i] settles before an edge. rise/fall assert in the same cycle so changes.
- General latency: SYNC_STAGES cycles plus THRES ticks, with up to one extra CDIV of jitter from tick phase.
- hold asserts HOLD_TICKS ticks after the rise pulse, registered, for one cycle.
- All outputs are registered; there are no combinational paths from si.
- Outputs are 0 during the first cycle after rst deasserts. The first tick occurs CDIV cycles after reset release.

## Test plan
Unless stated, all scenarios use CDIV=4, THRES=3, SYNC_STAGES=2, HOLD_TICKS=5, WIDTH=4.
- Reset: drive si=4'hF and hold rst high for 10 cycles → so, rise, fall, hold and tick all 0; the first tick comes 4 cycles after release.
- Clean press: si[0]=1 held → so[0] rises on the 3rd tick that samples s[0]=1, with rise[0] high one cycle; 5 ticks later hold[0] pulses once; no further hold while held.
- Glitch reject: si[1] high for 2 ticks, low 1 tick, high 2 ticks, then low → so[1], rise[1] and hold[1] stay 0 throughout.
- Release: from so[0]=1, drive si[0]=0 → fall[0] pulses on the 3rd low sample; hc clears; a re-press restarts the hold count from 0.
- Simultaneous channels: si 4'b0000→4'b1010 at the same edge → rise=4'b1010 in the same single cycle; so=4'b1010.
- Mid-operation reset and CDIV=1 / THRES=1: assert rst when cnt=2 → the counter clears and so stays 0. With CDIV=1, THRES=1, SYNC_STAGES=2, so follows si exactly 3 cycles later.
